// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed stream FIFO: skid depth and width helpers.
package ram_fifo_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned PTR_W(input int unsigned dd);
    return 32'($clog2(dd)) + 32'd1;
  endfunction

  // Total-count width: must hold 0..DD+SKID_DEPTH.
  function automatic int unsigned CNT_W(input int unsigned dd);
    return 32'($clog2(dd)) + 32'd2;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// RAM_TYPE selects the implementation style hint ("distributed", "block", "ultra").
module sdp_ram #(
  parameter int unsigned DW       = 512,
  parameter int unsigned DD       = 16384,
  parameter string       RAM_TYPE = "ultra"
) (
  input  logic                  clk,
  input  logic                  wea,
  input  logic [$clog2(DD)-1:0] addra,
  input  logic [DW-1:0]         dia,
  input  logic                  enb,
  input  logic [$clog2(DD)-1:0] addrb,
  output logic [DW-1:0]         dob
);

  logic [DW-1:0] dob_q;

  assign dob = dob_q;

  if (RAM_TYPE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [DW-1:0] mem [DD];
    // Write port and registered read port.
    always_ff @(posedge clk) begin
      if (wea) mem[addra] <= dia;
      if (enb) dob_q <= mem[addrb];
    end
  end else if (RAM_TYPE == "block") begin : g_block
    (* ram_style = "block" *) logic [DW-1:0] mem [DD];
    // Write port and registered read port.
    always_ff @(posedge clk) begin
      if (wea) mem[addra] <= dia;
      if (enb) dob_q <= mem[addrb];
    end
  end else begin : g_ultra
    (* ram_style = "ultra" *) logic [DW-1:0] mem [DD];
    // Write port and registered read port.
    always_ff @(posedge clk) begin
      if (wea) mem[addra] <= dia;
      if (enb) dob_q <= mem[addrb];
    end
  end

endmodule

// File: rtl/ram_fifo.sv
// Synchronous FIFO around one sdp_ram, AXI-Stream in and out, with a two-entry
// output skid stage that hides the RAM read latency.
// Optional RAM_FIFO_COUNT_EN: registered total occupancy on `count`; tied to 0 otherwise.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DW       = 512,
  parameter int unsigned DD       = 16384,
  parameter string       RAM_TYPE = "ultra"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          in_tdata,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic [DW-1:0]          out_tdata,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [CNT_W(DD)-1:0]   count
);

  localparam int unsigned AW = $clog2(DD);
  localparam int unsigned PW = PTR_W(DD);
  localparam int unsigned CW = CNT_W(DD);

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW-1:0] occ_c, occ_d;
  logic          inflight_q, inflight_d;
  skid_cnt_t     skid_cnt_q, skid_cnt_d;
  logic [DW-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
  logic          in_tready_q, in_tready_d;
  logic          out_tvalid_q, out_tvalid_d;
  logic          wr_c, rd_c, pop_c;
  logic [DW-1:0] dob;

  assign in_tready  = in_tready_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = skid0_q;

  // Pointer, read-issue and skid-stage next-state logic.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    inflight_d = 1'b0;
    skid_cnt_d = skid_cnt_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;

    occ_c = wp_q - rp_q;
    wr_c  = in_tvalid & in_tready_q;
    pop_c = out_tvalid_q & out_tready;
    // Issue only if the skid stage will have room when the data lands.
    rd_c  = (occ_c != '0) &&
            ((3'(skid_cnt_q) + 3'(inflight_q)) < (3'(SKID_DEPTH) + 3'(pop_c)));

    if (wr_c) wp_d = wp_q + PW'(1);
    if (rd_c) begin
      rp_d       = rp_q + PW'(1);
      inflight_d = 1'b1;
    end

    case ({inflight_q, pop_c})
      2'b10: begin
        if (skid_cnt_q == 2'd0) skid0_d = dob;
        else                    skid1_d = dob;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = dob;
        end else begin
          skid0_d = skid1_q;
          skid1_d = dob;
        end
      end
      default: ;
    endcase

    occ_d        = wp_d - rp_d;
    in_tready_d  = (occ_d != PW'(DD));
    out_tvalid_d = (skid_cnt_d != 2'd0);
  end

  // Control and skid registers; reset discards all buffered contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      inflight_q   <= 1'b0;
      skid_cnt_q   <= '0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      in_tready_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      inflight_q   <= inflight_d;
      skid_cnt_q   <= skid_cnt_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      in_tready_q  <= in_tready_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

`ifdef RAM_FIFO_COUNT_EN
  logic [CW-1:0] count_q, count_d;

  // Total words held: RAM + in-flight read + skid entries.
  always_comb begin
    count_d = CW'(occ_d) + CW'(inflight_d) + CW'(skid_cnt_d);
  end

  // Occupancy counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
`else
  assign count = CW'(0);
`endif

  sdp_ram #(
    .DW       (DW),
    .DD       (DD),
    .RAM_TYPE (RAM_TYPE)
  ) u_ram (
    .clk   (clk),
    .wea   (wr_c),
    .addra (wp_q[AW-1:0]),
    .dia   (in_tdata),
    .enb   (rd_c),
    .addrb (rp_q[AW-1:0]),
    .dob   (dob)
  );

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo: a DD=16 instance for ordering, fill, streaming,
// backpressure and reset, and a DD=4 instance for pointer wrap-around.
module tb_ram_fifo;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [31:0] a_in_tdata, a_out_tdata;
  logic        a_in_tvalid, a_in_tready, a_out_tvalid, a_out_tready;
  logic [5:0]  a_count;

  logic [31:0] b_in_tdata, b_out_tdata;
  logic        b_in_tvalid, b_in_tready, b_out_tvalid, b_out_tready;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_fifo #(.DW(32), .DD(16), .RAM_TYPE("block")) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (a_in_tdata),
    .in_tvalid  (a_in_tvalid),
    .in_tready  (a_in_tready),
    .out_tdata  (a_out_tdata),
    .out_tvalid (a_out_tvalid),
    .out_tready (a_out_tready),
    .count      (a_count)
  );

  ram_fifo #(.DW(32), .DD(4), .RAM_TYPE("distributed")) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (b_in_tdata),
    .in_tvalid  (b_in_tvalid),
    .in_tready  (b_in_tready),
    .out_tdata  (b_out_tdata),
    .out_tvalid (b_out_tvalid),
    .out_tready (b_out_tready),
    .count      (b_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n, got, gaps;
    logic        hs, started, stall_prev;
    logic [31:0] prev_data, exp_w;
    logic [31:0] sb[$];

    a_in_tdata = '0; a_in_tvalid = 1'b0; a_out_tready = 1'b0;
    b_in_tdata = '0; b_in_tvalid = 1'b0; b_out_tready = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_out_tvalid", 64'(a_out_tvalid), 64'(0));
    chk("rst_in_tready",  64'(a_in_tready),  64'(0));
    chk("rst_count",      64'(a_count),      64'(0));
    chk("rst_b_in_tready", 64'(b_in_tready), 64'(0));
    chk("rst_b_count",    64'(b_count),      64'(0));
    reset = 1'b0;
    cyc();
    chk("in_tready_after_rst", 64'(a_in_tready), 64'(1));

    // Basic order: 0x1..0x5, out_tvalid three cycles after first handshake
    a_out_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a_in_tvalid = (c < 5);
      a_in_tdata  = 32'(c + 1);
      chk($sformatf("basic_valid_c%0d", c), 64'(a_out_tvalid), 64'(c >= 3 && c < 8));
      if (c >= 3 && c < 8)
        chk($sformatf("basic_data_c%0d", c), 64'(a_out_tdata), 64'(c - 2));
      cyc();
    end
    a_in_tvalid = 1'b0;

    // Fill with consumer stalled: DD + 2 words accepted
    a_out_tready = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      a_in_tvalid = 1'b1;
      a_in_tdata  = 32'h100 + 32'(n);
      hs = a_in_tready;
      cyc();
      if (hs) n++;
    end
    a_in_tvalid = 1'b0;
    chk("fill_accepted",   64'(n),            64'(18));
    chk("fill_in_tready",  64'(a_in_tready),  64'(0));
    chk("fill_out_tvalid", 64'(a_out_tvalid), 64'(1));
    chk("fill_head",       64'(a_out_tdata),  64'(32'h100));
`ifdef RAM_FIFO_COUNT_EN
    chk("fill_count", 64'(a_count), 64'(18));
`else
    chk("fill_count", 64'(a_count), 64'(0));
`endif

    // Drain all 18 in order
    a_out_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 18; c++) begin
      if (a_out_tvalid) begin
        chk($sformatf("drain_data_%0d", got), 64'(a_out_tdata), 64'(32'h100 + 32'(got)));
        got++;
      end
      cyc();
    end
    chk("drain_words",     64'(got),          64'(18));
    chk("drain_empty",     64'(a_out_tvalid), 64'(0));
    chk("drain_in_tready", 64'(a_in_tready),  64'(1));
    chk("drain_count",     64'(a_count),      64'(0));

    // Full-throughput streaming of 1000 words
    n = 0; got = 0; gaps = 0; started = 1'b0;
    for (int c = 0; c < 1200 && got < 1000; c++) begin
      a_in_tvalid = (n < 1000);
      a_in_tdata  = 32'(n) + 32'h1000;
      hs = a_in_tvalid && a_in_tready;
      if (a_out_tvalid) begin
        chk("stream_data", 64'(a_out_tdata), 64'(32'(got) + 32'h1000));
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      cyc();
      if (hs) n++;
    end
    a_in_tvalid = 1'b0;
    chk("stream_words", 64'(got),  64'(1000));
    chk("stream_gaps",  64'(gaps), 64'(0));

    // Random backpressure with scoreboard and stall-stability checks
    n = 0; got = 0; stall_prev = 1'b0; prev_data = '0;
    for (int c = 0; c < 4000 && got < 300; c++) begin
      a_in_tvalid  = (n < 300) && ($urandom_range(0, 1) == 1);
      a_in_tdata   = $urandom;
      a_out_tready = ($urandom_range(0, 1) == 1);
      if (stall_prev) begin
        chk("bp_hold_valid", 64'(a_out_tvalid), 64'(1));
        chk("bp_hold_data",  64'(a_out_tdata),  64'(prev_data));
      end
      if (a_in_tvalid && a_in_tready) begin
        sb.push_back(a_in_tdata);
        n++;
      end
      if (a_out_tvalid && a_out_tready) begin
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("bp_data", 64'(a_out_tdata), 64'(exp_w));
        end else begin
          chk("bp_spurious_out", 64'(a_out_tvalid), 64'(0));
        end
        got++;
      end
      stall_prev = a_out_tvalid && !a_out_tready;
      prev_data  = a_out_tdata;
      cyc();
    end
    a_in_tvalid  = 1'b0;
    a_out_tready = 1'b1;
    chk("bp_words", 64'(got), 64'(300));
    repeat (5) cyc();
    chk("bp_empty", 64'(a_out_tvalid), 64'(0));

    // DD=4: fill to 6, then stream 3*DD words across pointer wrap
    b_out_tready = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      b_in_tvalid = 1'b1;
      b_in_tdata  = 32'h200 + 32'(n);
      hs = b_in_tready;
      cyc();
      if (hs) n++;
    end
    b_in_tvalid = 1'b0;
    chk("wrap_fill_accepted", 64'(n), 64'(6));
    chk("wrap_fill_in_tready", 64'(b_in_tready), 64'(0));
`ifdef RAM_FIFO_COUNT_EN
    chk("wrap_fill_count", 64'(b_count), 64'(6));
`else
    chk("wrap_fill_count", 64'(b_count), 64'(0));
`endif
    sb.delete();
    for (int i = 0; i < 6; i++) sb.push_back(32'h200 + 32'(i));
    got = 0;
    for (int c = 0; c < 400 && got < 18; c++) begin
      b_in_tvalid  = (n < 18);
      b_in_tdata   = 32'h200 + 32'(n);
      b_out_tready = (c % 3 != 0);
      if (b_in_tvalid && b_in_tready) begin
        sb.push_back(b_in_tdata);
        n++;
      end
      if (b_out_tvalid && b_out_tready) begin
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("wrap_data", 64'(b_out_tdata), 64'(exp_w));
        end else begin
          chk("wrap_spurious_out", 64'(b_out_tvalid), 64'(0));
        end
        got++;
      end
      cyc();
    end
    b_in_tvalid = 1'b0;
    chk("wrap_words", 64'(got), 64'(18));
    chk("wrap_empty", 64'(b_out_tvalid), 64'(0));
    chk("wrap_in_tready", 64'(b_in_tready), 64'(1));

    // Mid-stream reset with 10 words buffered
    a_out_tready = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      a_in_tvalid = 1'b1;
      a_in_tdata  = 32'h500 + 32'(n);
      hs = a_in_tready;
      cyc();
      if (hs) n++;
    end
    a_in_tvalid = 1'b0;
    cyc();
    cyc();
    chk("mrst_pre_valid", 64'(a_out_tvalid), 64'(1));
`ifdef RAM_FIFO_COUNT_EN
    chk("mrst_pre_count", 64'(a_count), 64'(10));
`else
    chk("mrst_pre_count", 64'(a_count), 64'(0));
`endif
    #2 reset = 1'b1;
    #1;
    chk("mrst_async_valid",   64'(a_out_tvalid), 64'(0));
    chk("mrst_async_tready",  64'(a_in_tready),  64'(0));
    cyc();
    reset = 1'b0;
    cyc();
    chk("mrst_post_count",  64'(a_count),      64'(0));
    chk("mrst_post_valid",  64'(a_out_tvalid), 64'(0));
    chk("mrst_post_tready", 64'(a_in_tready),  64'(1));
    a_out_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a_in_tvalid = (c == 0);
      a_in_tdata  = 32'hABC;
      chk($sformatf("mrst_valid_c%0d", c), 64'(a_out_tvalid), 64'(c == 3));
      if (c == 3) chk("mrst_first_data", 64'(a_out_tdata), 64'(32'hABC));
      cyc();
    end
    a_in_tvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
